// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame-format defaults.
// Imported by uart_rx (and uart_tx) so both ends agree on the encoding.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Ports:
//   i_clk  - destination clock
//   i_rst  - synchronous active-high reset, loads RST_VAL into both flops
//   i_d    - asynchronous input
//   o_q    - synchronised output (2 cycles of latency)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      // stage 0: may go metastable; stage 1: settled copy
      meta_p0 <= i_d;
      sync_p1 <= meta_p0;
    end
  end

  assign o_q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1 by default, LSB first, idle-high line).
// Checks the start bit at mid-bit, samples each data bit and the stop bit at
// mid-bit, and presents the byte on a valid/ready handshake.
// Ports:
//   i_clk           - system clock
//   i_rst           - synchronous active-high reset
//   i_rx_serial     - asynchronous serial line, idle high
//   i_baud_tick_16x - one-cycle strobe at OVERSAMPLE x baud
//   i_rx_ready      - consumer accepts the held byte
//   o_rx_data       - received byte, stable while o_rx_valid
//   o_rx_valid      - byte available, held until accepted
//   o_rx_busy       - frame in progress (state other than IDLE)
//   o_frame_err     - one-cycle pulse: stop bit sampled low
//   o_overrun       - one-cycle pulse: byte completed while previous still held
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  input  logic                 i_baud_tick_16x,
  input  logic                 i_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_d, vld_p1;
  logic                 ferr_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx_serial),
    .o_q   (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    deliver_d  = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (i_baud_tick_16x) begin
          if (tick_cnt_q == TICK_HALF) begin
            // a line that is high again at mid start bit was only a glitch
            if (!rx_s) begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = ST_DATA;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_baud_tick_16x) begin
          if (tick_cnt_q == TICK_LAST) begin
            // right shift: the first bit received ends up at bit 0
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (i_baud_tick_16x) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            // leaving at mid stop bit gives half a bit of resync slack
            if (rx_s) begin
              deliver_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // a held-low line must not retrigger a new frame
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // stage 0 -> 1: frame state, mid-stop delivery request and framing error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      vld_p1      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      vld_p1      <= deliver_d;
      o_frame_err <= ferr_d;
    end
  end

  // stage 1 -> 2: handshake output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (vld_p1) begin
        // an accept in the delivery cycle frees the slot for the new byte
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_data  <= shift_q;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_busy = (state_q != ST_IDLE);

endmodule
